// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared RV32 constants and the next-PC select encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HOLD     = 2'd2,
    SEL_TRAP     = 2'd3
  } next_pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register; flush > bubble > load, otherwise hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc4_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_pc    <= '0;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (bubble) begin
      // PC fields keep the last real instruction's address
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (load) begin
      r_pc    <= pc_in;
      r_pc4   <= pc4_in;
      r_instr <= instr_in;
      r_valid <= 1'b1;
    end
  end

  assign pc_out    = r_pc;
  assign pc4_out   = r_pc4;
  assign instr_out = r_instr;
  assign valid_out = r_valid;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : RV32IM IF stage - PC register, PC+4, next-PC select, IF/ID capture.
// Options  : MISALIGN_TRAP_EN - misaligned redirect goes to TRAP_VECTOR and
//            pulses fetch_fault; otherwise target bits [1:0] are cleared.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            hazard_stall,
  input  logic            imem_busywait,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_read,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic            fetch_fault
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_target_aligned;
  logic [XLEN-1:0] w_next_pc;
  next_pc_sel_e    w_sel;
  logic            w_load;
  logic            w_bubble;
  logic            w_flush;

  assign w_pc4            = r_pc + 32'd4;
  assign w_target_aligned = branch_target & ~32'h0000_0003;

  always_comb begin
    w_sel = SEL_SEQ;
    if (branch_taken) begin
`ifdef MISALIGN_TRAP_EN
      w_sel = (branch_target[1:0] != 2'b00) ? SEL_TRAP : SEL_REDIRECT;
`else
      w_sel = SEL_REDIRECT;
`endif
    end else if (hazard_stall || imem_busywait) begin
      w_sel = SEL_HOLD;
    end
  end

  always_comb begin
    w_next_pc = w_pc4;
    case (w_sel)
      SEL_SEQ:      w_next_pc = w_pc4;
      SEL_REDIRECT: w_next_pc = w_target_aligned;
      SEL_HOLD:     w_next_pc = r_pc;
      SEL_TRAP:     w_next_pc = TRAP_VECTOR;
      default:      w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // A redirect abandons any in-flight fetch, stalled or not
  assign w_flush  = branch_taken;
  assign w_bubble = !branch_taken && !hazard_stall && imem_busywait;
  assign w_load   = (w_sel == SEL_SEQ);

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .bubble    (w_bubble),
    .flush     (w_flush),
    .pc_in     (r_pc),
    .pc4_in    (w_pc4),
    .instr_in  (imem_rdata),
    .pc_out    (ifid_pc),
    .pc4_out   (ifid_pc4),
    .instr_out (ifid_instr),
    .valid_out (ifid_valid)
  );

`ifdef MISALIGN_TRAP_EN
  logic r_fetch_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_fault <= 1'b0;
    end else begin
      r_fetch_fault <= (w_sel == SEL_TRAP);
    end
  end

  assign fetch_fault = r_fetch_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign imem_read = !reset;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Scoreboard bench for pc_fetch_unit (honours MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        hazard_stall = 1'b0;
  logic        imem_busywait = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_fault;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .imem_busywait (imem_busywait),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .imem_read     (imem_read),
    .ifid_pc       (ifid_pc),
    .ifid_pc4      (ifid_pc4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .fetch_fault   (fetch_fault)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic        rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic        m_valid;
  logic        m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0033;
  endfunction

  // One clock: drive at negedge, predict with the model, compare after the edge
  task automatic cycle(input string tag, input logic r, input logic bt,
                       input logic [31:0] tgt, input logic st, input logic bw);
    exp_t e;
    logic f;
    @(negedge clk);
    if (m_known) check({tag, "_addr_pre"}, imem_addr, m_pc);
    reset         = r;
    branch_taken  = bt;
    branch_target = tgt;
    hazard_stall  = st;
    imem_busywait = bw;
    imem_rdata    = bw ? 32'hDEAD_BEEF : mem_word(m_pc);
    f = 1'b0;
    if (r) begin
      m_pc = RV; m_ifpc = '0; m_ifpc4 = '0; m_instr = NOP_INSTR; m_valid = 1'b0;
      m_known = 1'b1;
    end else if (bt) begin
`ifdef MISALIGN_TRAP_EN
      f    = (tgt[1:0] != 2'b00);
      m_pc = f ? TV : {tgt[31:2], 2'b00};
`else
      m_pc = {tgt[31:2], 2'b00};
`endif
      m_ifpc = '0; m_ifpc4 = '0; m_instr = NOP_INSTR; m_valid = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (bw) begin
      m_instr = NOP_INSTR; m_valid = 1'b0;
    end else begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = imem_rdata; m_valid = 1'b1;
      m_pc   = m_pc + 32'd4;
    end
    e.tag = tag; e.pc = m_pc; e.ifpc = m_ifpc; e.ifpc4 = m_ifpc4; e.instr = m_instr;
    e.valid = m_valid; e.fault = f; e.rd = !r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_addr"},  imem_addr,  e.pc);
      check({e.tag, "_ifpc"},  ifid_pc,    e.ifpc);
      check({e.tag, "_ifpc4"}, ifid_pc4,   e.ifpc4);
      check({e.tag, "_instr"}, ifid_instr, e.instr);
      check({e.tag, "_valid"}, {31'd0, ifid_valid},  {31'd0, e.valid});
      check({e.tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, e.fault});
      check({e.tag, "_read"},  {31'd0, imem_read},   {31'd0, e.rd});
    end
  endtask

  task automatic norm(input string tag);
    cycle(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, including one cycle with stall and busywait also asserted
    cycle("rst0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'h0000_0013);

    // Sequential fetch
    norm("t1a"); norm("t1b"); norm("t1c");
    check("t1_addr", imem_addr, 32'hC);
    check("t1_ifpc", ifid_pc, 32'h8);
    check("t1_ifpc4", ifid_pc4, 32'hC);

    // Redirect while PC=8
    cycle("rst2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    norm("t2a"); norm("t2b");
    check("t2_pc8", imem_addr, 32'h8);
    cycle("t2_br", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    check("t2_br_addr", imem_addr, 32'h40);
    check("t2_br_valid", {31'd0, ifid_valid}, 32'd0);
    norm("t2c");
    check("t2_ifpc", ifid_pc, 32'h40);

    // Busywait at PC=0x10
    cycle("t3_br", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("t3_bw", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("t3_bw_addr", imem_addr, 32'h10);
    end
    norm("t3_go");
    check("t3_ifpc", ifid_pc, 32'h10);
    check("t3_instr", ifid_instr, mem_word(32'h10));

    // Hazard stall with IFID_PC=4
    cycle("rst3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    norm("t4a"); norm("t4b");
    for (int i = 0; i < 2; i++) begin
      cycle("t4_st", 1'b0, 1'b0, 32'h0, 1'b1, (i == 1));
      check("t4_st_ifpc", ifid_pc, 32'h4);
    end
    norm("t4c"); norm("t4d");
    check("t4_resume", ifid_pc, 32'hC);

    // PC wrap and reset during busywait
    cycle("t5_br", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    norm("t5_wrap");
    check("t5_wrap_addr", imem_addr, 32'h0);
    check("t5_wrap_pc4", ifid_pc4, 32'h0);
    norm("t5b");
    cycle("t5_bw", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("t5_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_rst_addr", imem_addr, RV);

    // Misaligned and aligned redirects, redirects during stall/busywait
    norm("t6a");
    cycle("t6_mis", 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("t6_mis_addr", imem_addr, TV);
    check("t6_mis_fault", {31'd0, fetch_fault}, 32'd1);
`else
    check("t6_mis_addr", imem_addr, 32'h40);
    check("t6_mis_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    norm("t6_after");
    cycle("t6_al", 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    cycle("t6_st_br", 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    check("t6_st_br_addr", imem_addr, 32'h200);
    cycle("t6_bw_br", 1'b0, 1'b1, 32'h303, 1'b0, 1'b1);
    norm("t6_end");

    // Random mix
    for (int i = 0; i < 300; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      cycle("rand",
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 12),
            t,
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
